// File: rtl/divisor_pkg.sv
// Shared types and constants for the repeated-subtraction divider.
package divisor_pkg;

   localparam int unsigned W_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      DONE = 2'd2
   } estado_t;

endpackage

// File: rtl/restador.sv
// Unsigned W-bit subtractor: diff = (a - b) mod 2^W, carri_out = borrow (a < b).
module restador #(
   parameter int unsigned W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] diff,
   output logic         carri_out
);

   assign {carri_out, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/divisor_restas.sv
// Sequential unsigned divider: counts successful subtractions of the divisor
// from the running remainder, using restador as the only subtractor.
module divisor_restas
   import divisor_pkg::*;
#(
   parameter int unsigned W = W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         ready,
   output logic         done,
   output logic [W-1:0] quotient,
   output logic [W-1:0] remainder,
   output logic         div_zero
);

   estado_t      state_q, state_d;
   logic [W-1:0] div_q, div_d;
   logic [W-1:0] rem_q, rem_d;
   logic [W-1:0] quo_q, quo_d;
   logic         dz_q, dz_d;

   logic [W-1:0] diff;
   logic         borrow;

   restador #(.W(W)) u_restador (
      .a         (rem_q),
      .b         (div_q),
      .diff      (diff),
      .carri_out (borrow)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         div_q <= '0;
         rem_q <= '0;
         quo_q <= '0;
         dz_q  <= 1'b0;
      end else begin
         div_q <= div_d;
         rem_q <= rem_d;
         quo_q <= quo_d;
         dz_q  <= dz_d;
      end
   end

   // Next state and datapath updates
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dz_d    = dz_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               div_d = divisor;
               rem_d = dividend;
               quo_d = '0;
               dz_d  = 1'b0;
               if (divisor == '0) begin
                  // Divide by zero: report all-ones quotient, dividend as remainder
                  quo_d   = '1;
                  dz_d    = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d = SUB;
               end
            end
         end
         SUB: begin
            if (!borrow) begin
               rem_d = diff;
               quo_d = quo_q + W'(1);
            end else begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign ready     = (state_q == IDLE);
   assign done      = (state_q == DONE);
   assign quotient  = quo_q;
   assign remainder = rem_q;
   assign div_zero  = dz_q;

endmodule

// File: tb/tb_divisor_restas.sv
// Scoreboard bench for divisor_restas: driver pushes expected results, a
// done-triggered monitor pops and compares values and latency.
module tb_divisor_restas;

   localparam int unsigned W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         ready;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_zero;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
      int           due;
   } exp_t;

   exp_t sb[$];

   divisor_restas #(.W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .ready     (ready),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag(input string name);
      checks++;
      errors++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Reference: integer division; divisor 0 gives all-ones quotient and the dividend back
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int acc);
      exp_t e;
      int   ia;
      int   ib;
      ia = int'(a);
      ib = int'(b);
      if (ib == 0) begin
         e.q   = '1;
         e.r   = a;
         e.dz  = 1'b1;
         e.due = acc + 1;
      end else begin
         e.q   = W'(ia / ib);
         e.r   = W'(ia % ib);
         e.dz  = 1'b0;
         e.due = acc + 2 + ia / ib;
      end
      return e;
   endfunction

   // Monitor: every done pulse must match the oldest outstanding request
   always @(negedge clk) begin
      if (done) begin
         if (sb.size() == 0) begin
            flag("unexpected_done");
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("quotient",   32'(quotient),  32'(e.q));
            check("remainder",  32'(remainder), 32'(e.r));
            check("div_zero",   32'(div_zero),  32'(e.dz));
            check("done_cycle", 32'(cyc),       32'(e.due));
            check("ready_in_done", 32'(ready),  32'(0));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!ready && n < 64) begin
         step();
         n++;
      end
      if (!ready) flag("ready_timeout");
   endtask

   // Present operands with start high for the accepting edge; start is left high
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
      wait_ready();
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      sb.push_back(model(a, b, cyc));
      step();
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_ready"},     32'(ready),     32'(1));
      check({tag, "_done"},      32'(done),      32'(0));
      check({tag, "_quotient"},  32'(quotient),  32'(0));
      check({tag, "_remainder"}, 32'(remainder), 32'(0));
      check({tag, "_div_zero"},  32'(div_zero),  32'(0));
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      step();
      step();
      check_idle_zero("reset");
      rst = 1'b0;

      issue(4'd13, 4'd4);
      start = 1'b0;

      // 15/1 with a stray start in cycle 8 that must be ignored
      issue(4'd15, 4'd1);
      start = 1'b0;
      repeat (7) step();
      check("busy_ready", 32'(ready), 32'(0));
      dividend = 4'd2;
      divisor  = 4'd2;
      start    = 1'b1;
      step();
      start = 1'b0;

      issue(4'd3, 4'd7);
      start = 1'b0;
      issue(4'd9, 4'd0);
      start = 1'b0;
      issue(4'd6, 4'd3);
      start = 1'b0;

      // Reset in cycle 4 of 15/1 aborts the operation
      issue(4'd15, 4'd1);
      start = 1'b0;
      repeat (3) step();
      rst = 1'b1;
      void'(sb.pop_back());
      step();
      rst = 1'b0;
      check_idle_zero("abort");
      issue(4'd7, 4'd7);
      start = 1'b0;

      repeat (40) begin
         issue(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
         start = 1'b0;
         repeat ($urandom_range(0, 3)) step();
      end

      // Exhaustive sweep with start held high throughout
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            issue(W'(a), W'(b));
         end
      end
      start = 1'b0;

      begin
         int n = 0;
         while (sb.size() != 0 && n < 100) begin
            step();
            n++;
         end
         if (sb.size() != 0) flag("scoreboard_drain");
      end
      repeat (3) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/divisor_restas.md
# divisor_restas

Sequential unsigned divider built around the team's existing `restador` subtractor. It divides by repeated subtraction: the running remainder goes to `restador.a`, the divisor to `restador.b`, and the quotient counts successful subtractions. This is the first block that sequences the subtractor instead of driving it combinationally. It is the controller that arithmetic exercises in this codebase instantiate to get quotient and remainder from a start/done handshake.

## Interface
- `W`, default 4: operand width; must equal the width of the instantiated `restador`.
- `clk` input 1: single clock; every register updates on the rising edge.
- `rst` input 1: one clock; reset is synchronous and active-high.
- `start` input 1: request; accepted only in a cycle where `ready`=1.
- `dividend` input W: unsigned dividend, sampled on an accepted `start`.
- `divisor` input W: unsigned divisor, sampled on an accepted `start`.
- `ready` output 1: high only in state IDLE.
- `done` output 1: one-cycle pulse; result is valid from this cycle onward.
- `quotient` output W: result quotient, held until the next accepted `start`.
- `remainder` output W: result remainder, held until the next accepted `start`.
- `div_zero` output 1: set with the result when `divisor`=0; cleared on the next accepted `start`.

## Operation
- `restador` convention:
  - `diff` = (a − b) mod 2^W.
  - `carri_out`=1 means borrow, i.e. a < b.
  - The controller treats `carri_out`=0 as "subtraction fits".
- States are IDLE, SUB and DONE.
- IDLE:
  - `ready`=1.
  - On `start`: latch `divisor` into the divisor register, load the remainder register with `dividend`, clear the quotient register, clear `div_zero`.
  - If `divisor`=0, go to DONE instead of SUB, with `div_zero`=1, `quotient`=all ones and `remainder`=`dividend`.
- SUB:
  - `restador` inputs are a = remainder register, b = divisor register.
  - If `carri_out`=0: remainder register ← `diff`, quotient register ← quotient + 1, stay in SUB.
  - If `carri_out`=1: registers unchanged, go to DONE.
- DONE: assert `done` for exactly one cycle, then return to IDLE.
- `quotient` and `remainder` are driven directly from their registers; they change only in SUB or on an accepted `start`.
- Quotient overflow is impossible: there are at most 2^W−1 successful subtractions (dividend max, divisor 1). No saturation logic is needed.
- `start` while `ready`=0 (SUB or DONE) is ignored entirely; it is neither queued nor latched.
- `start` held high continuously: a new operation is accepted on every IDLE cycle, i.e. the cycle after each `done`.
- Operand inputs are don't-care except in the accepting cycle.

## Timing
- Reset values, applied at the first rising edge with `rst`=1:
  - state = IDLE, `ready`=1.
  - `done`=0, `div_zero`=0, `quotient`=0, `remainder`=0.
- `rst` overrides everything, including an in-progress SUB and a same-cycle `start`.
- `start` accepted at edge 0 with divisor ≠ 0 and true quotient q:
  - SUB occupies cycles 1 … q+1.
  - `done`=1 in cycle q+2.
  - `ready` returns to 1 in cycle q+3.
- Divisor = 0: `done`=1 in cycle 1, `ready`=1 in cycle 2.
- Worst case for W=4 (15/1): `done` in cycle 17.
- `done` and `ready` are never high in the same cycle.
- All outputs are registered or decoded from state; there is no combinational path from inputs to outputs.

## Structure
- Package `divisor_pkg`:
  - state enum `estado_t` {IDLE, SUB, DONE}.
  - default width constant `W_DEF`=4.
- One sub-module only: `restador`, instantiated unchanged with ports a, b, diff, carri_out.
- No other arithmetic in the controller apart from the quotient incrementer.
- Estimated size is about 120–160 lines, FSM plus datapath registers.

## Test plan
- 13 / 4, start at cycle 0 → `quotient`=3, `remainder`=1, `div_zero`=0, `done` pulse in cycle 5 only.
- 15 / 1 → `quotient`=15, `remainder`=0, `done` in cycle 17. A `start` pulse in cycle 8 is ignored and the result is unchanged.
- 3 / 7 → `quotient`=0, `remainder`=3, `done` in cycle 2 (one SUB cycle, borrow immediately).
- 9 / 0 → `div_zero`=1, `quotient`=15, `remainder`=9, `done` in cycle 1. The next 6 / 3 gives `div_zero`=0, `quotient`=2, `remainder`=0.
- `rst` asserted in cycle 4 of 15 / 1 → next cycle shows IDLE, all outputs 0, no `done`. A following 7 / 7 gives `quotient`=1, `remainder`=0, `done` in cycle 3.
- Exhaustive W=4 sweep of all 256 operand pairs with `start` held high:
  - each result matches integer `/` and `%` (divisor 0 handled as above).
  - `done` latency is q+2.
